// File: rtl/time_display_driver_if.sv
// Display-side bundle: packed time value and page select in, multiplexed
// common-anode 7-segment drive out.
interface time_display_driver_if;
    logic [26:0] in_time;
    logic        page_sw;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    // Source of the time value / consumer of the pin drive
    modport master (output in_time, output page_sw, input an, input seg, input dp);
    // The display driver itself
    modport slave  (input in_time, input page_sw, output an, output seg, output dp);
endinterface

// File: rtl/time_display_driver.sv
// 4-digit time-multiplexed 7-segment driver. Once per display frame the
// selected pair of time fields is converted to BCD by a sequential
// double-dabble engine and committed to all four digit registers at once.
module time_display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    time_display_driver_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT_A = 3'd2,
        SHIFT_B = 3'd3,
        COMMIT  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] refresh_cnt_r;
    logic [1:0]       digit_idx_r;
    logic             wrap_s;
    logic             frame_start_s;

    state_t           state_r;
    state_t           state_next_s;
    logic [3:0]       shift_cnt_r;
    logic [9:0]       bin_a_r;
    logic [9:0]       bin_b_r;
    logic [11:0]      bcd_a_r;
    logic [11:0]      bcd_b_r;
    logic             page_r;
    logic             clamp_r;
    logic [3:0][3:0]  digits_r;

    logic [3:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;

    // One double-dabble iteration: correct every nibble >= 5, then shift in the next bit
    function automatic logic [11:0] dabble_step(input logic [11:0] bcd, input logic bit_in);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end else begin
                adj[i*4 +: 4] = adj[i*4 +: 4];
            end
        end
        return {adj[10:0], bit_in};
    endfunction

    // Active-low {g,f,e,d,c,b,a} pattern; non-decimal codes blank the digit
    function automatic logic [6:0] seg_encode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    assign wrap_s        = (refresh_cnt_r == CNT_MAX);
    assign frame_start_s = wrap_s && (digit_idx_r == 2'd3);

    // Refresh timebase and digit scan index
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt_r <= '0;
            digit_idx_r   <= 2'd0;
        end else if (wrap_s) begin
            refresh_cnt_r <= '0;
            digit_idx_r   <= digit_idx_r + 2'd1;
        end else begin
            refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
        end
    end

    // Conversion FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Conversion FSM next-state: one LOAD, ten shifts per operand, one COMMIT
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (frame_start_s) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD:    state_next_s = SHIFT_A;
            SHIFT_A: begin
                if (shift_cnt_r == 4'd9) begin
                    state_next_s = SHIFT_B;
                end else begin
                    state_next_s = SHIFT_A;
                end
            end
            SHIFT_B: begin
                if (shift_cnt_r == 4'd9) begin
                    state_next_s = COMMIT;
                end else begin
                    state_next_s = SHIFT_B;
                end
            end
            COMMIT:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Conversion datapath: snapshot, binary-to-BCD shifting, atomic digit commit
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_cnt_r <= 4'd0;
            bin_a_r     <= 10'd0;
            bin_b_r     <= 10'd0;
            bcd_a_r     <= 12'd0;
            bcd_b_r     <= 12'd0;
            page_r      <= 1'b0;
            clamp_r     <= 1'b0;
            digits_r    <= '0;
        end else begin
            case (state_r)
                LOAD: begin
                    page_r      <= bus.page_sw;
                    clamp_r     <= bus.page_sw && (bus.in_time[9:0] > 10'd999);
                    bin_a_r     <= bus.page_sw ? {4'd0, bus.in_time[15:10]} : {5'd0, bus.in_time[26:22]};
                    bin_b_r     <= bus.page_sw ? bus.in_time[9:0] : {4'd0, bus.in_time[21:16]};
                    bcd_a_r     <= 12'd0;
                    bcd_b_r     <= 12'd0;
                    shift_cnt_r <= 4'd0;
                end
                SHIFT_A: begin
                    bcd_a_r     <= dabble_step(bcd_a_r, bin_a_r[9]);
                    bin_a_r     <= {bin_a_r[8:0], 1'b0};
                    shift_cnt_r <= (shift_cnt_r == 4'd9) ? 4'd0 : shift_cnt_r + 4'd1;
                end
                SHIFT_B: begin
                    bcd_b_r     <= dabble_step(bcd_b_r, bin_b_r[9]);
                    bin_b_r     <= {bin_b_r[8:0], 1'b0};
                    shift_cnt_r <= (shift_cnt_r == 4'd9) ? 4'd0 : shift_cnt_r + 4'd1;
                end
                COMMIT: begin
                    digits_r[3] <= bcd_a_r[7:4];
                    digits_r[2] <= bcd_a_r[3:0];
                    if (!page_r) begin
                        digits_r[1] <= bcd_b_r[7:4];
                        digits_r[0] <= bcd_b_r[3:0];
                    end else if (clamp_r) begin
                        digits_r[1] <= 4'd9;
                        digits_r[0] <= 4'd9;
                    end else begin
                        digits_r[1] <= bcd_b_r[11:8];
                        digits_r[0] <= bcd_b_r[7:4];
                    end
                end
                default: begin
                    shift_cnt_r <= shift_cnt_r;
                end
            endcase
        end
    end

    // Registered pin drive for the digit currently being scanned
    always_ff @(posedge clk) begin
        if (reset) begin
            an_r  <= 4'b1111;
            seg_r <= 7'b1111111;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= ~(4'b0001 << digit_idx_r);
            seg_r <= seg_encode(digits_r[digit_idx_r]);
            dp_r  <= (digit_idx_r == 2'd2) ? 1'b0 : 1'b1;
        end
    end

    assign bus.an  = an_r;
    assign bus.seg = seg_r;
    assign bus.dp  = dp_r;

endmodule
